// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI read or write out, one response back.
// Define AXIL_MASTER_TIMEOUT_EN to build the watchdog that drives the timeout flag.
module axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [1:0]                  bresp,
  output logic                        arvalid,
  input  logic                        arready,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic                        rvalid,
  output logic                        rready,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp,
  output logic                        timeout
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic                      aw_done;
  logic                      w_done;
  logic                      cmd_fire;
  logic                      aw_complete;
  logic                      w_complete;

  // Payload registers drive the AXI buses directly, so they stay stable while valids are held.
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign aw_complete = aw_done || (awvalid && awready);
  assign w_complete  = w_done  || (wvalid  && wready);

  // NOTE: state is updated with non-blocking assignments only, so every branch sees the pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            rsp_write <= cmd_write;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WRITE;
            end else begin
              arvalid <= 1'b1;
              state   <= S_RD_ADDR;
            end
          end
        end
        S_WRITE: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_complete && w_complete) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] wd_count;
  logic        wd_busy;

  assign wd_busy = (state == S_WRITE) || (state == S_WR_RESP) ||
                   (state == S_RD_ADDR) || (state == S_RD_DATA);

  // The flag is sticky for the whole transaction; the FSM keeps waiting regardless.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else if (cmd_fire) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else if (wd_busy && (wd_count != 16'hFFFF)) begin
      wd_count <= wd_count + 16'd1;
      if ((wd_count + 16'd1) == TIMEOUT_LIMIT) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a delay-configurable AXI4-Lite slave plus a word-array reference model.
// The timeout scenario runs when AXIL_MASTER_TIMEOUT_EN is defined; otherwise timeout must stay 0.
module tb_axi_lite_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          timeout;

  axi_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .timeout(timeout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Slave configuration and observation state, owned by the slave process.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_code = 2'b00, r_code = 2'b00;
  int aw_got = 0, w_got = 0, b_done = 0, ar_got = 0, r_done = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_armed = 0, w_armed = 0, b_armed = 0, ar_armed = 0, r_armed = 0;
  bit aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [AW-1:0] aw_hold_addr, ar_hold_addr, aw_cap, ar_cap;
  logic [DW-1:0] w_hold_data, w_cap_data;
  logic [SW-1:0] w_hold_strb, w_cap_strb;
  int viol = 0;
  string viol_name = "none";

  logic [DW-1:0] slave_mem [0:1023];
  logic [DW-1:0] ref_mem   [0:1023];

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge aclk);
      if (areset === 1'b1) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_armed = 0; w_armed = 0; b_armed = 0; ar_armed = 0; r_armed = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_done = 0; ar_got = 0; r_done = 0;
      end else begin
        // Retire handshakes that completed at the previous rising edge.
        if (aw_armed) begin aw_armed = 0; awready = 0; aw_hold = 0; aw_got++; end
        if (w_armed)  begin w_armed = 0;  wready = 0;  w_hold = 0;  w_got++;  end
        if (ar_armed) begin ar_armed = 0; arready = 0; ar_hold = 0; ar_got++; end
        if (b_armed)  begin b_armed = 0;  bvalid = 0;  b_done++; end
        if (r_armed)  begin r_armed = 0;  rvalid = 0;  r_done++; end

        if (awvalid === 1'b1) begin
          if (aw_hold && awaddr !== aw_hold_addr) begin viol++; viol_name = "awaddr moved under awvalid"; end
          aw_hold = 1; aw_hold_addr = awaddr;
          if (!awready) begin
            if (aw_cnt >= aw_dly) begin awready = 1; aw_armed = 1; aw_cnt = 0; aw_cap = awaddr; end
            else aw_cnt++;
          end
        end else aw_hold = 0;

        if (wvalid === 1'b1) begin
          if (w_hold && (wdata !== w_hold_data || wstrb !== w_hold_strb)) begin viol++; viol_name = "wdata moved under wvalid"; end
          w_hold = 1; w_hold_data = wdata; w_hold_strb = wstrb;
          if (!wready) begin
            if (w_cnt >= w_dly) begin wready = 1; w_armed = 1; w_cnt = 0; w_cap_data = wdata; w_cap_strb = wstrb; end
            else w_cnt++;
          end
        end else w_hold = 0;

        if (bready === 1'b1 && !(aw_got > b_done && w_got > b_done)) begin viol++; viol_name = "bready before aw and w"; end
        if (!bvalid && aw_got > b_done && w_got > b_done) begin
          if (b_cnt >= b_dly) begin
            bvalid = 1; bresp = b_code; b_cnt = 0;
            for (int b = 0; b < SW; b++)
              if (w_cap_strb[b]) slave_mem[aw_cap[11:2]][8*b +: 8] = w_cap_data[8*b +: 8];
          end else b_cnt++;
        end
        if (bvalid && bready === 1'b1) b_armed = 1;

        if (arvalid === 1'b1) begin
          if (ar_hold && araddr !== ar_hold_addr) begin viol++; viol_name = "araddr moved under arvalid"; end
          ar_hold = 1; ar_hold_addr = araddr;
          if (!arready) begin
            if (ar_cnt >= ar_dly) begin arready = 1; ar_armed = 1; ar_cnt = 0; ar_cap = araddr; end
            else ar_cnt++;
          end
        end else ar_hold = 0;

        if (rready === 1'b1 && !(ar_got > r_done)) begin viol++; viol_name = "rready outside read data phase"; end
        if (!rvalid && ar_got > r_done) begin
          if (r_cnt >= r_dly) begin rvalid = 1; rdata = slave_mem[ar_cap[11:2]]; rresp = r_code; r_cnt = 0; end
          else r_cnt++;
        end
        if (rvalid && rready === 1'b1) r_armed = 1;

        if (cmd_ready === 1'b1 && rsp_valid === 1'b1) begin viol++; viol_name = "cmd_ready while rsp_valid"; end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1 ms");
    $fatal(1, "bench watchdog expired");
  end

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++)
      if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // Presents one command starting at a falling edge; acc is the cycle count right after the accept edge.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int acc);
    int n = 0;
    acc = -1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      return;
    end
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    acc = cyc + 1;
    @(negedge aclk);
    cmd_valid = 0; cmd_write = 1'($urandom);
    cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
  endtask

  task automatic get_rsp(input int hold, output int rcyc, output logic r_wr,
                         output logic [DW-1:0] r_data, output logic [1:0] r_resp);
    int n = 0;
    rcyc = -1; r_wr = 0; r_data = '0; r_resp = '0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
      return;
    end
    rcyc = cyc; r_wr = rsp_write; r_data = rsp_rdata; r_resp = rsp_resp;
    repeat (hold) @(negedge aclk);
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 00000000", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout});
    end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_write} !== '0) begin
      failures++;
      $display("FAIL reset_payload: rdata=%h resp=%0d write=%b, required all 0", rsp_rdata, rsp_resp, rsp_write);
    end
    areset = 0;
    @(negedge aclk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release: cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    int acc, rc; logic w; logic [DW-1:0] d; logic [1:0] r;
    set_delays(0, 0, 0, 0, 0); b_code = 2'b00;
    send_cmd(1'b1, 12'h004, 32'h0000_00A5, 4'hF, acc);
    checks++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 12'h004 || wdata !== 32'h0000_00A5 || wstrb !== 4'hF) begin
      failures++;
      $display("FAIL wr_issue: awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%h, required 1 1 004 000000a5 f",
               awvalid, wvalid, awaddr, wdata, wstrb);
    end
    get_rsp(0, rc, w, d, r);
    model_write(12'h004, 32'h0000_00A5, 4'hF);
    checks++;
    if (rc - acc !== 2) begin failures++; $display("FAIL wr_latency: rsp_valid %0d cycles after accept, required 2", rc - acc); end
    checks++;
    if (w !== 1'b1 || d !== '0 || r !== 2'b00) begin
      failures++; $display("FAIL wr_rsp: write=%b rdata=%h resp=%0d, required 1 00000000 0", w, d, r);
    end
  endtask

  task automatic test_read_delayed();
    int acc, rc, n; logic w; logic [DW-1:0] d; logic [1:0] r; logic [DW-1:0] exp;
    set_delays(0, 0, 0, 3, 2); r_code = 2'b00;
    exp = ref_mem[12'h02C >> 2];
    send_cmd(1'b0, 12'h02C, 32'hDEAD_BEEF, 4'h0, acc);
    n = 0;
    while (arvalid === 1'b1 && n < 20) begin
      checks++;
      if (araddr !== 12'h02C) begin failures++; $display("FAIL rd_araddr: araddr=%h, required 02c", araddr); end
      n++;
      @(negedge aclk);
    end
    checks++;
    if (n !== 4) begin failures++; $display("FAIL rd_arvalid_len: arvalid high %0d cycles, required 4", n); end
    get_rsp(0, rc, w, d, r);
    checks++;
    if (w !== 1'b0 || d !== exp || r !== 2'b00) begin
      failures++; $display("FAIL rd_rsp: write=%b rdata=%h resp=%0d, required 0 %h 0", w, d, r, exp);
    end
  endtask

  task automatic test_write_ordering();
    int aw_d[3] = '{5, 0, 2};
    int w_d[3]  = '{0, 5, 2};
    for (int i = 0; i < 3; i++) begin
      int acc, rc, aw0, w0; logic w; logic [DW-1:0] d; logic [1:0] r;
      logic [AW-1:0] a; logic [DW-1:0] dat;
      a = 12'h200 + AW'(i * 4); dat = $urandom;
      set_delays(aw_d[i], w_d[i], 0, 0, 0); b_code = 2'b00;
      aw0 = aw_got; w0 = w_got;
      send_cmd(1'b1, a, dat, 4'hF, acc);
      get_rsp(0, rc, w, d, r);
      model_write(a, dat, 4'hF);
      checks++;
      if (aw_got - aw0 !== 1 || w_got - w0 !== 1) begin
        failures++; $display("FAIL order_hs_%0d: aw handshakes=%0d w handshakes=%0d, required 1 1", i, aw_got - aw0, w_got - w0);
      end
      checks++;
      if (w !== 1'b1 || r !== 2'b00 || aw_cap !== a || w_cap_data !== dat) begin
        failures++; $display("FAIL order_rsp_%0d: write=%b resp=%0d awaddr=%h wdata=%h, required 1 0 %h %h", i, w, r, aw_cap, w_cap_data, a, dat);
      end
    end
  endtask

  task automatic test_error_backpressure();
    int acc, n, rc; logic w; logic [DW-1:0] d; logic [1:0] r;
    logic [DW-1:0] exp, snap_d; logic [1:0] snap_r;
    set_delays(0, 0, 0, 1, 1); r_code = 2'b10;
    exp = ref_mem[12'h02C >> 2];
    send_cmd(1'b0, 12'h02C, '0, '0, acc);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    snap_d = rsp_rdata; snap_r = rsp_resp;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h300;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap_d || rsp_resp !== snap_r || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: rsp_valid=%b rdata=%h resp=%0d cmd_ready=%b, required 1 %h %0d 0",
                 i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, snap_d, snap_r);
      end
      @(negedge aclk);
    end
    cmd_valid = 0;
    get_rsp(0, rc, w, d, r);
    checks++;
    if (r !== 2'b10 || d !== exp || w !== 1'b0) begin
      failures++; $display("FAIL err_rresp: resp=%0d rdata=%h write=%b, required 2 %h 0", r, d, w, exp);
    end
    r_code = 2'b00; b_code = 2'b11;
    send_cmd(1'b1, 12'h008, 32'h1234_5678, 4'h3, acc);
    get_rsp(2, rc, w, d, r);
    model_write(12'h008, 32'h1234_5678, 4'h3);
    b_code = 2'b00;
    checks++;
    if (r !== 2'b11 || d !== '0) begin failures++; $display("FAIL err_bresp: resp=%0d rdata=%h, required 3 00000000", r, d); end
  endtask

  task automatic test_reset_mid_write();
    int acc, rc; logic w; logic [DW-1:0] d; logic [1:0] r;
    set_delays(10, 10, 0, 0, 0);
    send_cmd(1'b1, 12'h040, 32'hAAAA_5555, 4'hF, acc);
    @(negedge aclk);
    checks++;
    if (awvalid !== 1'b1) begin failures++; $display("FAIL rst_pre: awvalid=%b, required 1", awvalid); end
    areset = 1;
    @(negedge aclk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid: outputs=%b, required 0000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    end
    @(negedge aclk);
    areset = 0;
    set_delays(0, 0, 0, 0, 0);
    @(negedge aclk);
    send_cmd(1'b1, 12'h044, 32'h0BAD_F00D, 4'hF, acc);
    get_rsp(0, rc, w, d, r);
    model_write(12'h044, 32'h0BAD_F00D, 4'hF);
    checks++;
    if (rc - acc !== 2 || w !== 1'b1 || r !== 2'b00 || aw_cap !== 12'h044) begin
      failures++; $display("FAIL rst_after: latency=%0d write=%b resp=%0d awaddr=%h, required 2 1 0 044", rc - acc, w, r, aw_cap);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rc; logic w; logic [DW-1:0] d; logic [1:0] r;
    set_delays(0, 0, 0, 0, 0);
    send_cmd(1'b1, 12'h080, 32'hC0FF_EE00, 4'hF, acc1);
    get_rsp(0, rc, w, d, r);
    model_write(12'h080, 32'hC0FF_EE00, 4'hF);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: cmd_ready=%b after rsp handshake, required 1", cmd_ready); end
    send_cmd(1'b0, 12'h080, '0, '0, acc2);
    get_rsp(0, rc, w, d, r);
    checks++;
    if (acc2 - acc1 !== 4) begin failures++; $display("FAIL b2b_interval: %0d cycles between accepts, required 4", acc2 - acc1); end
    checks++;
    if (rc - acc2 !== 2 || d !== ref_mem[12'h080 >> 2]) begin
      failures++; $display("FAIL b2b_read: latency=%0d rdata=%h, required 2 %h", rc - acc2, d, ref_mem[12'h080 >> 2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int acc, rc; logic w; logic [DW-1:0] d; logic [1:0] r;
      logic wr; logic [AW-1:0] a; logic [DW-1:0] dat; logic [SW-1:0] s;
      logic [DW-1:0] exp_d; logic [1:0] exp_r;
      wr = 1'($urandom);
      a = 12'h100 + {7'd0, 3'($urandom_range(0, 7)), 2'b00};
      dat = $urandom; s = SW'($urandom_range(1, 15));
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      b_code = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      r_code = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      exp_d = wr ? '0 : ref_mem[a[11:2]];
      exp_r = wr ? b_code : r_code;
      send_cmd(wr, a, dat, s, acc);
      get_rsp($urandom_range(0, 2), rc, w, d, r);
      if (wr) model_write(a, dat, s);
      checks++;
      if (w !== wr || d !== exp_d || r !== exp_r) begin
        failures++; $display("FAIL rand_rsp_%0d: write=%b rdata=%h resp=%0d, required %b %h %0d", i, w, d, r, wr, exp_d, exp_r);
      end
      checks++;
      if (wr ? (aw_cap !== a || w_cap_data !== dat || w_cap_strb !== s) : (ar_cap !== a)) begin
        failures++; $display("FAIL rand_bus_%0d: awaddr=%h araddr=%h wdata=%h wstrb=%h, required addr %h data %h strb %h",
                             i, aw_cap, ar_cap, w_cap_data, w_cap_strb, a, dat, s);
      end
    end
    b_code = 2'b00; r_code = 2'b00;
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int acc, rc, n; logic w; logic [DW-1:0] d; logic [1:0] r;
    set_delays(0, 0, 20, 0, 0);
    send_cmd(1'b1, 12'h0C0, 32'h5A5A_5A5A, 4'hF, acc);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      checks++;
      if (timeout !== ((cyc - acc) >= TO)) begin
        failures++; $display("FAIL timeout_rise: timeout=%b at %0d cycles after accept, required %b", timeout, cyc - acc, (cyc - acc) >= TO);
      end
      n++;
      @(negedge aclk);
    end
    get_rsp(0, rc, w, d, r);
    model_write(12'h0C0, 32'h5A5A_5A5A, 4'hF);
    checks++;
    if (w !== 1'b1 || r !== 2'b00 || timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_done: write=%b resp=%0d timeout=%b, required 1 0 1", w, r, timeout);
    end
    set_delays(0, 0, 0, 0, 0);
    send_cmd(1'b0, 12'h0C0, '0, '0, acc);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: timeout=%b after accept, required 0", timeout); end
    get_rsp(0, rc, w, d, r);
  endtask
`else
  task automatic test_timeout();
    int acc, rc, n; logic w; logic [DW-1:0] d; logic [1:0] r;
    set_delays(0, 0, 20, 0, 0);
    send_cmd(1'b1, 12'h0C0, 32'h5A5A_5A5A, 4'hF, acc);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      checks++;
      if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_off: timeout=%b at %0d cycles, required 0", timeout, cyc - acc); end
      n++;
      @(negedge aclk);
    end
    get_rsp(0, rc, w, d, r);
    model_write(12'h0C0, 32'h5A5A_5A5A, 4'hF);
    set_delays(0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL protocol: %0d violations, last '%s', required 0", viol, viol_name); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end
    slave_mem[12'h02C >> 2] = 32'h0001_0000;
    ref_mem[12'h02C >> 2]   = 32'h0001_0000;
    test_reset();
    test_write_zero_wait();
    test_read_delayed();
    test_write_ordering();
    test_error_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    test_timeout();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
